cmd_scheduler: RTL and testbench

CMD_SCHEDULER -- requirements
Module: cmd_scheduler

---
 rtl/cmd_scheduler_pkg.sv | 52 +++++
 rtl/sensor_timeout_timer.sv | 26 ++
 rtl/cmd_scheduler.sv | 155 +++++++++++++++
 tb/tb_cmd_scheduler.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cmd_scheduler_pkg.sv
// Shared encodings for the sensor command scheduler: FSM states, command bytes,
// response codes and sensor operation codes.
package cmd_scheduler_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StDecode,
    StStart,
    StWaitSensor,
    StSendCode,
    StWaitCode,
    StSendData,
    StWaitData
  } state_e;

  localparam logic [7:0] CmdStatus    = 8'h01;
  localparam logic [7:0] CmdTemp      = 8'h02;
  localparam logic [7:0] CmdHumid     = 8'h03;
  localparam logic [7:0] CmdContTemp  = 8'h04;
  localparam logic [7:0] CmdContHumid = 8'h05;
  localparam logic [7:0] CmdStop      = 8'h06;

  localparam logic [7:0] RespStatus    = 8'h07;
  localparam logic [7:0] RespTemp      = 8'h08;
  localparam logic [7:0] RespHumid     = 8'h09;
  localparam logic [7:0] RespStopped   = 8'h0A;
  localparam logic [7:0] RespBadAddr   = 8'hE0;
  localparam logic [7:0] RespBadCmd    = 8'hE1;
  localparam logic [7:0] RespSensorErr = 8'hE2;

  localparam logic [1:0] OpStatus = 2'd0;
  localparam logic [1:0] OpTemp   = 2'd1;
  localparam logic [1:0] OpHumid  = 2'd2;

  // Sensor operation for any read-type command (single or continuous).
  function automatic logic [1:0] cmd_op(input logic [7:0] cmd);
    case (cmd)
      CmdTemp, CmdContTemp:   return OpTemp;
      CmdHumid, CmdContHumid: return OpHumid;
      default:                return OpStatus;
    endcase
  endfunction

  function automatic logic [7:0] op_resp_code(input logic [1:0] op);
    case (op)
      OpTemp:  return RespTemp;
      OpHumid: return RespHumid;
      default: return RespStatus;
    endcase
  endfunction

endpackage

// File: rtl/sensor_timeout_timer.sv
// Free-running wait counter for sensor responses; held at zero while clear is high,
// expired flags the last allowed cycle.
module sensor_timeout_timer #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  output logic expired
);

  logic [31:0] count_q;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count_q <= 32'd0;
    end else if (clear) begin
      count_q <= 32'd0;
    end else begin
      count_q <= count_q + 32'd1;
    end
  end

  assign expired = (count_q == TIMEOUT_CYCLES - 1);

endmodule

// File: rtl/cmd_scheduler.sv
// Turns 2-byte UART requests into sensor reads and 2-byte responses, with an
// optional continuous repoll mode.
module cmd_scheduler #(
  parameter int unsigned TIMEOUT_CYCLES = 5_000_000,
  parameter int unsigned ADDR_MAX       = 31
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rx_done,
  input  logic [7:0] rx_address,
  input  logic [7:0] rx_command,
  output logic [4:0] sensor_sel,
  output logic [1:0] sensor_op,
  output logic       sensor_start,
  input  logic       sensor_done,
  input  logic [7:0] sensor_data,
  input  logic       sensor_error,
  output logic [7:0] tx_data,
  output logic       tx_start,
  input  logic       tx_done,
  output logic       cont_active
);
  import cmd_scheduler_pkg::*;

  state_e      state_q;
  logic        rx_prev_q, pending_q;
  logic [7:0]  pend_addr_q, pend_cmd_q, cur_addr_q, cur_cmd_q, resp_data_q;
  logic [4:0]  cont_sel_q;
  logic [1:0]  cont_op_q;
  logic        rx_edge, timer_clear, timer_expired;

  assign rx_edge     = rx_done & ~rx_prev_q;
  // Counting starts with the sensor_start cycle so the timeout lines up with it.
  assign timer_clear = (state_q != StStart) && (state_q != StWaitSensor);

  sensor_timeout_timer #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timer (
    .clock  (clock),
    .reset  (reset),
    .clear  (timer_clear),
    .expired(timer_expired)
  );

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= StIdle;
      // Held high so an rx_done already asserted at release is not seen as an edge.
      rx_prev_q    <= 1'b1;
      pending_q    <= 1'b0;
      pend_addr_q  <= 8'd0;
      pend_cmd_q   <= 8'd0;
      cur_addr_q   <= 8'd0;
      cur_cmd_q    <= 8'd0;
      resp_data_q  <= 8'd0;
      cont_sel_q   <= 5'd0;
      cont_op_q    <= 2'd0;
      cont_active  <= 1'b0;
      sensor_sel   <= 5'd0;
      sensor_op    <= 2'd0;
      sensor_start <= 1'b0;
      tx_data      <= 8'd0;
      tx_start     <= 1'b0;
    end else begin
      rx_prev_q    <= rx_done;
      sensor_start <= 1'b0;
      tx_start     <= 1'b0;
      if (rx_edge) begin
        pending_q   <= 1'b1;
        pend_addr_q <= rx_address;
        pend_cmd_q  <= rx_command;
      end

      unique case (state_q)
        StIdle: begin
          if (pending_q) begin
            if (!rx_edge) pending_q <= 1'b0;
            cur_addr_q <= pend_addr_q;
            cur_cmd_q  <= pend_cmd_q;
            state_q    <= StDecode;
          end else if (cont_active) begin
            sensor_sel   <= cont_sel_q;
            sensor_op    <= cont_op_q;
            sensor_start <= 1'b1;
            state_q      <= StStart;
          end
        end
        StDecode: begin
          if ({24'd0, cur_addr_q} > ADDR_MAX) begin
            tx_data     <= RespBadAddr;
            resp_data_q <= 8'd0;
            tx_start    <= 1'b1;
            state_q     <= StSendCode;
          end else begin
            case (cur_cmd_q)
              CmdStatus, CmdTemp, CmdHumid, CmdContTemp, CmdContHumid: begin
                if (cur_cmd_q == CmdContTemp || cur_cmd_q == CmdContHumid) begin
                  cont_active <= 1'b1;
                  cont_sel_q  <= cur_addr_q[4:0];
                  cont_op_q   <= cmd_op(cur_cmd_q);
                end
                sensor_sel   <= cur_addr_q[4:0];
                sensor_op    <= cmd_op(cur_cmd_q);
                sensor_start <= 1'b1;
                state_q      <= StStart;
              end
              CmdStop: begin
                cont_active <= 1'b0;
                tx_data     <= RespStopped;
                resp_data_q <= 8'd0;
                tx_start    <= 1'b1;
                state_q     <= StSendCode;
              end
              default: begin
                tx_data     <= RespBadCmd;
                resp_data_q <= 8'd0;
                tx_start    <= 1'b1;
                state_q     <= StSendCode;
              end
            endcase
          end
        end
        StStart: state_q <= StWaitSensor;
        StWaitSensor: begin
          if (sensor_done || timer_expired) begin
            tx_start <= 1'b1;
            state_q  <= StSendCode;
            if (sensor_done && !sensor_error) begin
              tx_data     <= op_resp_code(sensor_op);
              resp_data_q <= sensor_data;
            end else begin
              tx_data     <= RespSensorErr;
              resp_data_q <= 8'd0;
              cont_active <= 1'b0;
            end
          end
        end
        StSendCode: state_q <= StWaitCode;
        StWaitCode: begin
          if (tx_done) begin
            tx_data  <= resp_data_q;
            tx_start <= 1'b1;
            state_q  <= StSendData;
          end
        end
        StSendData: state_q <= StWaitData;
        StWaitData: begin
          if (tx_done) state_q <= StIdle;
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_cmd_scheduler.sv
// Directed bench for cmd_scheduler: auto-responding sensor and UART transmitter models,
// hand-computed expected response bytes.
module tb_cmd_scheduler;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       rx_done = 1'b0;
  logic [7:0] rx_address = 8'd0;
  logic [7:0] rx_command = 8'd0;
  logic       sensor_done = 1'b0;
  logic [7:0] sensor_data = 8'd0;
  logic       sensor_error = 1'b0;
  logic       tx_done = 1'b0;
  logic       use_b = 1'b0;

  logic [4:0] a_sel, b_sel, sensor_sel_m;
  logic [1:0] a_op, b_op, sensor_op_m;
  logic       a_sstart, b_sstart, sensor_start_m;
  logic [7:0] a_txd, b_txd, tx_data_m;
  logic       a_txs, b_txs, tx_start_m;
  logic       a_cont, b_cont, cont_active_m;

  always #5 clock = ~clock;

  // Instance a has a long timeout for the normal scenarios, instance b a short one.
  cmd_scheduler #(.TIMEOUT_CYCLES(200), .ADDR_MAX(31)) dut_a (
    .clock(clock), .reset(reset), .rx_done(rx_done), .rx_address(rx_address),
    .rx_command(rx_command), .sensor_sel(a_sel), .sensor_op(a_op), .sensor_start(a_sstart),
    .sensor_done(sensor_done), .sensor_data(sensor_data), .sensor_error(sensor_error),
    .tx_data(a_txd), .tx_start(a_txs), .tx_done(tx_done), .cont_active(a_cont)
  );

  cmd_scheduler #(.TIMEOUT_CYCLES(50), .ADDR_MAX(31)) dut_b (
    .clock(clock), .reset(reset), .rx_done(rx_done), .rx_address(rx_address),
    .rx_command(rx_command), .sensor_sel(b_sel), .sensor_op(b_op), .sensor_start(b_sstart),
    .sensor_done(sensor_done), .sensor_data(sensor_data), .sensor_error(sensor_error),
    .tx_data(b_txd), .tx_start(b_txs), .tx_done(tx_done), .cont_active(b_cont)
  );

  assign sensor_sel_m   = use_b ? b_sel    : a_sel;
  assign sensor_op_m    = use_b ? b_op     : a_op;
  assign sensor_start_m = use_b ? b_sstart : a_sstart;
  assign tx_data_m      = use_b ? b_txd    : a_txd;
  assign tx_start_m     = use_b ? b_txs    : a_txs;
  assign cont_active_m  = use_b ? b_cont   : a_cont;

  int n_cmp = 0;
  int n_err = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Responder state, written only by the monitor below.
  int         cyc = 0;
  int         tx_cnt = -1;
  int         sens_cnt = -1;
  int         start_cnt = 0;
  int         start_cyc = 0;
  logic [4:0] last_sel = 5'd0;
  logic [1:0] last_op = 2'd0;
  logic [7:0] last_tx = 8'd0;
  logic [7:0] tx_q[$];
  int         tx_cyc_q[$];

  // Sensor model configuration, written only by the stimulus block.
  int         sens_delay = 5;
  logic [7:0] sens_data = 8'd0;
  logic       sens_err = 1'b0;
  logic       sens_on = 1'b1;

  always @(negedge clock) begin
    cyc++;
    tx_done      = 1'b0;
    sensor_done  = 1'b0;
    sensor_data  = 8'd0;
    sensor_error = 1'b0;
    if (reset) begin
      tx_cnt   = -1;
      sens_cnt = -1;
    end else begin
      if (tx_cnt == 0) begin
        tx_done = 1'b1;
        tx_cnt  = -1;
        check_eq("tx_hold", {24'd0, tx_data_m}, {24'd0, last_tx});
      end else if (tx_cnt > 0) begin
        tx_cnt--;
      end
      if (tx_start_m) begin
        tx_q.push_back(tx_data_m);
        tx_cyc_q.push_back(cyc);
        last_tx = tx_data_m;
        tx_cnt  = 3;
      end
      if (sens_cnt == 0) begin
        sensor_done  = 1'b1;
        sensor_data  = sens_data;
        sensor_error = sens_err;
        sens_cnt     = -1;
        check_eq("sel_stable", {25'd0, sensor_op_m, sensor_sel_m}, {25'd0, last_op, last_sel});
      end else if (sens_cnt > 0) begin
        sens_cnt--;
      end
      if (sensor_start_m) begin
        start_cnt++;
        last_sel  = sensor_sel_m;
        last_op   = sensor_op_m;
        start_cyc = cyc;
        if (sens_on) sens_cnt = sens_delay;
      end
    end
  end

  task automatic step();
    @(posedge clock);
    #2;
  endtask

  function automatic logic [7:0] get_tx(input int i);
    if (i < tx_q.size()) return tx_q[i];
    return 8'hxx;
  endfunction

  task automatic send_rx(input logic [7:0] addr, input logic [7:0] cmd);
    rx_address = addr;
    rx_command = cmd;
    rx_done    = 1'b1;
    step();
    step();
    rx_done = 1'b0;
    step();
  endtask

  task automatic wait_tx(input int n, input int budget);
    int k = 0;
    while ((tx_q.size() < n || tx_cnt >= 0) && k < budget) begin
      step();
      k++;
    end
    repeat (3) step();
    check_eq("tx_count", tx_q.size(), n);
  endtask

  // One single-shot request, checking the two response bytes and sensor accesses.
  task automatic run_req(input string tag, input logic [7:0] addr, input logic [7:0] cmd,
                         input logic [7:0] code, input logic [7:0] data, input int starts);
    int tb = tx_q.size();
    int sb = start_cnt;
    send_rx(addr, cmd);
    wait_tx(tb + 2, 600);
    check_eq({tag, "_code"}, {24'd0, get_tx(tb)}, {24'd0, code});
    check_eq({tag, "_data"}, {24'd0, get_tx(tb + 1)}, {24'd0, data});
    check_eq({tag, "_starts"}, start_cnt - sb, starts);
  endtask

  task automatic check_outputs_zero(input string tag);
    check_eq({tag, "_sstart"}, {31'd0, sensor_start_m}, 32'd0);
    check_eq({tag, "_txstart"}, {31'd0, tx_start_m}, 32'd0);
    check_eq({tag, "_cont"}, {31'd0, cont_active_m}, 32'd0);
    check_eq({tag, "_sel"}, {27'd0, sensor_sel_m}, 32'd0);
    check_eq({tag, "_op"}, {30'd0, sensor_op_m}, 32'd0);
    check_eq({tag, "_txdata"}, {24'd0, tx_data_m}, 32'd0);
  endtask

  initial begin
    int tb, sb, n, k;
    #1;
    check_outputs_zero("reset");
    repeat (3) step();
    reset = 1'b0;
    repeat (3) step();

    // Temperature read of sensor 5, data after ~100 cycles.
    sens_delay = 99;
    sens_data  = 8'h19;
    run_req("temp", 8'h05, 8'h02, 8'h08, 8'h19, 1);
    check_eq("temp_sel", {27'd0, last_sel}, 32'd5);
    check_eq("temp_op", {30'd0, last_op}, 32'd1);

    sens_delay = 5;
    run_req("badaddr", 8'h25, 8'h02, 8'hE0, 8'h00, 0);
    run_req("addr_prio", 8'h20, 8'h09, 8'hE0, 8'h00, 0);
    run_req("badcmd", 8'h03, 8'h09, 8'hE1, 8'h00, 0);
    run_req("badcmd0", 8'h03, 8'h00, 8'hE1, 8'h00, 0);
    sens_data = 8'h5A;
    run_req("status", 8'h01, 8'h01, 8'h07, 8'h5A, 1);
    check_eq("status_op", {30'd0, last_op}, 32'd0);
    sens_data = 8'h33;
    run_req("humid31", 8'h1F, 8'h03, 8'h09, 8'h33, 1);
    check_eq("humid31_sel", {27'd0, last_sel}, 32'd31);
    check_eq("humid31_op", {30'd0, last_op}, 32'd2);
    sens_err = 1'b1;
    run_req("senserr", 8'h02, 8'h02, 8'hE2, 8'h00, 1);
    sens_err = 1'b0;
    run_req("stop_idle", 8'h04, 8'h06, 8'h0A, 8'h00, 0);

    // Continuous humidity on sensor 2, then stop.
    sens_data = 8'h41;
    tb = tx_q.size();
    send_rx(8'h02, 8'h05);
    k = 0;
    while (tx_q.size() < tb + 6 && k < 400) begin
      step();
      k++;
    end
    check_eq("cont_on", {31'd0, cont_active_m}, 32'd1);
    check_eq("cont_sel", {27'd0, last_sel}, 32'd2);
    send_rx(8'h02, 8'h06);
    k = 0;
    while (k < 400) begin
      n = tx_q.size();
      if (n >= tb + 2 && tx_cnt < 0 && tx_q[n - 1] == 8'h00 && tx_q[n - 2] == 8'h0A) break;
      step();
      k++;
    end
    repeat (3) step();
    n = tx_q.size() - tb;
    check_eq("cont_stop_code", {24'd0, get_tx(tb + n - 2)}, 32'h0A);
    check_eq("cont_stop_data", {24'd0, get_tx(tb + n - 1)}, 32'h00);
    check_eq("cont_even", n % 2, 0);
    check_eq("cont_pairs", {31'd0, n >= 8}, 32'd1);
    for (int i = 0; i + 2 < n; i += 2) begin
      check_eq("cont_code", {24'd0, get_tx(tb + i)}, 32'h09);
      check_eq("cont_data", {24'd0, get_tx(tb + i + 1)}, 32'h41);
    end
    check_eq("cont_off", {31'd0, cont_active_m}, 32'd0);
    sb = start_cnt;
    tb = tx_q.size();
    repeat (100) step();
    check_eq("cont_quiet_starts", start_cnt - sb, 0);
    check_eq("cont_quiet_tx", tx_q.size(), tb);

    // A sensor fault ends continuous mode.
    sens_err = 1'b1;
    run_req("cont_err", 8'h03, 8'h04, 8'hE2, 8'h00, 1);
    sens_err = 1'b0;
    check_eq("cont_err_off", {31'd0, cont_active_m}, 32'd0);
    sb = start_cnt;
    repeat (50) step();
    check_eq("cont_err_quiet", start_cnt - sb, 0);

    // Reset in WAIT_CODE with rx_done held high across release.
    sens_data  = 8'h77;
    rx_address = 8'h01;
    rx_command = 8'h02;
    rx_done    = 1'b1;
    k = 0;
    while (!tx_start_m && k < 100) begin
      step();
      k++;
    end
    check_eq("rst_reach_send", {31'd0, tx_start_m}, 32'd1);
    step();
    reset = 1'b1;
    #1;
    check_outputs_zero("midrst");
    step();
    step();
    reset = 1'b0;
    sb = start_cnt;
    tb = tx_q.size();
    repeat (30) step();
    check_eq("rst_no_start", start_cnt - sb, 0);
    check_eq("rst_no_tx", tx_q.size(), tb);
    rx_done = 1'b0;
    step();
    run_req("after_rst", 8'h01, 8'h02, 8'h08, 8'h77, 1);

    // Timeout on the short-timeout instance.
    use_b   = 1'b1;
    sens_on = 1'b0;
    reset   = 1'b1;
    step();
    step();
    reset = 1'b0;
    repeat (3) step();
    tb = tx_q.size();
    run_req("timeout", 8'h01, 8'h01, 8'hE2, 8'h00, 1);
    check_eq("timeout_delay", (tb < tx_cyc_q.size()) ? tx_cyc_q[tb] - start_cyc : -1, 50);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
